// File: rtl/bitbakery_frame_tx.sv
// bitbakery_frame_tx: 8E1 UART frame transmitter (HEADER, payload LSB-byte first, [CHK], TRAILER).
// Define BITBAKERY_FRAME_CHECKSUM_EN to insert an XOR-of-payload checksum byte before TRAILER.
module bitbakery_frame_tx #(
    parameter int         N_BYTES = 11,
    parameter int         CLK_DIV = 434,
    parameter logic [7:0] HEADER  = 8'hFF,
    parameter logic [7:0] TRAILER = 8'hFE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iniciar,
    input  logic [8*N_BYTES-1:0] dados,
    output logic                 saida_serial,
    output logic                 ocupado,
    output logic                 fim_tx,
    output logic [2:0]           db_estado
);

`ifdef BITBAKERY_FRAME_CHECKSUM_EN
    localparam int F = N_BYTES + 3;
`else
    localparam int F = N_BYTES + 2;
`endif
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int IDX_W  = $clog2(N_BYTES + 3);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(F - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [8*N_BYTES-1:0] data_q, data_d;
    logic [7:0]           cur_byte;
    logic                 bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

`ifdef BITBAKERY_FRAME_CHECKSUM_EN
    logic [7:0] chk;
    always_comb begin
        chk = 8'h00;
        for (int k = 0; k < N_BYTES; k++) chk = chk ^ data_q[8*k +: 8];
    end
`endif

    // Byte index 0 is HEADER, 1..N_BYTES the payload, then [CHK], then TRAILER.
    always_comb begin
        cur_byte = TRAILER;
        if (idx_q == '0) cur_byte = HEADER;
        for (int k = 0; k < N_BYTES; k++) begin
            if (idx_q == IDX_W'(k + 1)) cur_byte = data_q[8*k +: 8];
        end
`ifdef BITBAKERY_FRAME_CHECKSUM_EN
        if (idx_q == IDX_W'(N_BYTES + 1)) cur_byte = chk;
`endif
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (iniciar) begin
                    state_d = START;
                    data_d  = dados;
                    baud_d  = '0;
                    bit_d   = '0;
                    idx_d   = '0;
                end
            end
            START:  if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = START;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        if (state_q inside {START, DATA, PARITY, STOP}) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            // NOTE: the payload snapshot is reset too; it is a plain register, not a RAM.
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        saida_serial = 1'b1;
        case (state_q)
            START:   saida_serial = 1'b0;
            DATA:    saida_serial = cur_byte[bit_q];
            PARITY:  saida_serial = ^cur_byte;
            default: saida_serial = 1'b1;
        endcase
    end

    assign ocupado   = state_q inside {START, DATA, PARITY, STOP};
    assign fim_tx    = (state_q == DONE);
    assign db_estado = state_q;

endmodule

// File: tb/tb_bitbakery_frame_tx.sv
// Self-checking bench for bitbakery_frame_tx: frames built from byte/bit queues, checked cycle by cycle.
module tb_bitbakery_frame_tx;

    localparam int         NB  = 2;
    localparam int         DIV = 4;
    localparam logic [7:0] HDR = 8'hFF;
    localparam logic [7:0] TRL = 8'hFE;
`ifdef BITBAKERY_FRAME_CHECKSUM_EN
    localparam int FB = NB + 3;
`else
    localparam int FB = NB + 2;
`endif
    localparam int FRAME_CYC = 11 * DIV * FB;

    logic            clock   = 1'b0;
    logic            reset   = 1'b0;
    logic            iniciar = 1'b0;
    logic [8*NB-1:0] dados   = '0;
    logic            saida_serial;
    logic            ocupado;
    logic            fim_tx;
    logic [2:0]      db_estado;

    int n_checks = 0;
    int n_fail   = 0;

    bitbakery_frame_tx #(
        .N_BYTES(NB),
        .CLK_DIV(DIV),
        .HEADER (HDR),
        .TRAILER(TRL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .dados       (dados),
        .saida_serial(saida_serial),
        .ocupado     (ocupado),
        .fim_tx      (fim_tx),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: plain frame; 1: dados cleared after capture; 2: extra iniciar pulses mid-frame.
    // abort_at >= 0 pulls reset low at that frame cycle.
    task automatic run_frame(input logic [8*NB-1:0] d, input int mode, input int abort_at);
        logic [7:0] bytes_q[$];
        logic       bits_q[$];
        logic       samp[FB*11];
        logic [7:0] chk;
        logic [7:0] got_byte;
        bit         aborted;

        aborted = 1'b0;
        chk     = 8'h00;
        bytes_q.push_back(HDR);
        for (int k = 0; k < NB; k++) begin
            bytes_q.push_back(d[8*k +: 8]);
            chk = chk ^ d[8*k +: 8];
        end
`ifdef BITBAKERY_FRAME_CHECKSUM_EN
        bytes_q.push_back(chk);
`endif
        bytes_q.push_back(TRL);
        foreach (bytes_q[j]) begin
            bits_q.push_back(1'b0);
            for (int b = 0; b < 8; b++) bits_q.push_back(bytes_q[j][b]);
            bits_q.push_back(^bytes_q[j]);
            bits_q.push_back(1'b1);
        end

        @(posedge clock); #1;
        dados   = d;
        iniciar = 1'b1;
        check("pre_accept_line", saida_serial, 1);
        @(posedge clock); #1;
        iniciar = 1'b0;
        if (mode == 1) dados = '0;

        for (int c = 0; c < FRAME_CYC && !aborted; c++) begin
            if (c > 0) begin
                @(posedge clock); #1;
            end
            check($sformatf("line_c%0d", c), saida_serial, bits_q[c / DIV]);
            check("ocupado_in_frame", ocupado, 1);
            check("fim_tx_early", fim_tx, 0);
            if (c % DIV == DIV / 2) samp[c / DIV] = saida_serial;
            if (mode == 2 && (c == 10 || c == 100)) iniciar = 1'b1;
            if (mode == 2 && (c == 11 || c == 101)) iniciar = 1'b0;
            if (c == abort_at) begin
                #2 reset = 1'b0;
                #1;
                check("abort_line", saida_serial, 1);
                check("abort_ocupado", ocupado, 0);
                check("abort_state", db_estado, 0);
                repeat (5) begin
                    @(posedge clock); #1;
                    check("abort_no_fim", fim_tx, 0);
                    check("abort_idle_line", saida_serial, 1);
                end
                @(negedge clock);
                reset   = 1'b1;
                aborted = 1'b1;
            end
        end

        if (!aborted) begin
            @(posedge clock); #1;
            check("fim_tx_pulse", fim_tx, 1);
            check("done_ocupado", ocupado, 0);
            check("done_state", db_estado, 5);
            check("done_line", saida_serial, 1);
            @(posedge clock); #1;
            check("fim_tx_width", fim_tx, 0);
            check("idle_state", db_estado, 0);
            for (int j = 0; j < FB; j++) begin
                got_byte = '0;
                for (int b = 0; b < 8; b++) got_byte[b] = samp[j*11 + 1 + b];
                check($sformatf("byte%0d", j), got_byte, bytes_q[j]);
                check($sformatf("start%0d", j), samp[j*11], 0);
                check($sformatf("parity%0d", j), samp[j*11 + 9], ^bytes_q[j]);
                check($sformatf("stop%0d", j), samp[j*11 + 10], 1);
            end
            if (mode == 2) begin
                repeat (30) begin
                    @(posedge clock); #1;
                    check("no_second_fim", fim_tx, 0);
                    check("no_second_frame", saida_serial, 1);
                    check("no_second_busy", ocupado, 0);
                end
            end
        end
    endtask

    initial begin
        logic [31:0] rnd;
        repeat (3) @(posedge clock);
        #1;
        check("rst_line", saida_serial, 1);
        check("rst_ocupado", ocupado, 0);
        check("rst_fim", fim_tx, 0);
        check("rst_state", db_estado, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (50) begin
            @(posedge clock); #1;
            check("idle_line", saida_serial, 1);
            check("idle_ocupado", ocupado, 0);
            check("idle_fim", fim_tx, 0);
            check("idle_state", db_estado, 0);
        end

        run_frame(16'hA503, 0, -1);
        run_frame(16'hA503, 1, -1);
        run_frame(16'hA503, 2, -1);
        run_frame(16'hA503, 0, 60);
        run_frame(16'hA503, 0, -1);
        repeat (6) begin
            rnd = $urandom;
            run_frame(rnd[8*NB-1:0], 0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
